color_centroid: RTL and testbench



---
 rtl/color_centroid_if.sv | 16 +
 rtl/color_centroid.sv | 213 +++++++++++++++++++++
 tb/tb_color_centroid.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/color_centroid_if.sv
// Pixel stream from the colour-reduction stage: thresholded HSV pixel,
// its coordinates, and the end-of-frame strobe.
`timescale 1ns/1ps
interface color_centroid_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  logic           pixel_valid;
  logic [23:0]    tHSV;
  logic [X_W-1:0] hcount;
  logic [Y_W-1:0] vcount;
  logic           frame_end;

  modport master (output pixel_valid, tHSV, hcount, vcount, frame_end);
  modport slave  (input  pixel_valid, tHSV, hcount, vcount, frame_end);
endinterface

// File: rtl/color_centroid.sv
// Colour centroid tracker: counts pixels equal to target_hsv, accumulates
// their coordinates over a frame, and at frame end divides the coordinate
// sums by the count with two parallel restoring dividers (one quotient bit
// per clock). Optional bounding-box outputs: define COLOR_CENTROID_BBOX_EN.
`timescale 1ns/1ps
module color_centroid #(
  parameter int X_W   = 11,
  parameter int Y_W   = 10,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  color_centroid_if.slave  pix,
  input  logic [23:0]      target_hsv,
  output logic             match,
  output logic [X_W-1:0]   centroid_x,
  output logic [Y_W-1:0]   centroid_y,
  output logic [CNT_W-1:0] match_count,
  output logic             result_valid,
  output logic             found,
  output logic             busy,
`ifdef COLOR_CENTROID_BBOX_EN
  output logic [X_W-1:0]   bbox_xmin,
  output logic [X_W-1:0]   bbox_xmax,
  output logic [Y_W-1:0]   bbox_ymin,
  output logic [Y_W-1:0]   bbox_ymax,
`endif
  output logic             overrun
);

  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  localparam int IT_W = $clog2(X_W + 2);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t           state;
  logic [IT_W-1:0]  iter;

  // Running per-frame accumulators
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SX_W-1:0]  sum_x, sx_nxt;
  logic [SY_W-1:0]  sum_y, sy_nxt;

  // Divider operands latched at the accepted frame_end, and working registers.
  // The low X_W dividend bits live in q_* and are replaced by quotient bits.
  logic [CNT_W-1:0] op_cnt;
  logic [SX_W-1:0]  op_sx, sy_ext;
  logic [SY_W-1:0]  op_sy;
  logic [CNT_W-1:0] rem_x, rem_y, rem_x_nxt, rem_y_nxt;
  logic [X_W-1:0]   q_x, q_y;
  logic [CNT_W:0]   trial_x, trial_y;
  logic             ge_x, ge_y;

  logic hit, acc_en, accept;

`ifdef COLOR_CENTROID_BBOX_EN
  logic [X_W-1:0] xmin, xmax, xmin_nxt, xmax_nxt, op_xmin, op_xmax;
  logic [Y_W-1:0] ymin, ymax, ymin_nxt, ymax_nxt, op_ymin, op_ymax;
`endif

  assign sy_ext = SX_W'(op_sy);

  // Match detection, accumulator next values and one divider step
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    hit     = pix.pixel_valid && (pix.tHSV == target_hsv);
    acc_en  = hit && !(&cnt);   // saturated count freezes sums too
    accept  = pix.frame_end && !busy;
    cnt_nxt = cnt;
    sx_nxt  = sum_x;
    sy_nxt  = sum_y;
    if (acc_en) begin
      cnt_nxt = cnt + CNT_W'(1);
      sx_nxt  = sum_x + SX_W'(pix.hcount);
      sy_nxt  = sum_y + SY_W'(pix.vcount);
    end
    trial_x   = {rem_x, q_x[X_W-1]};
    trial_y   = {rem_y, q_y[X_W-1]};
    ge_x      = trial_x >= {1'b0, op_cnt};
    ge_y      = trial_y >= {1'b0, op_cnt};
    rem_x_nxt = ge_x ? CNT_W'(trial_x - {1'b0, op_cnt}) : CNT_W'(trial_x);
    rem_y_nxt = ge_y ? CNT_W'(trial_y - {1'b0, op_cnt}) : CNT_W'(trial_y);
`ifdef COLOR_CENTROID_BBOX_EN
    xmin_nxt = xmin;
    xmax_nxt = xmax;
    ymin_nxt = ymin;
    ymax_nxt = ymax;
    if (hit) begin
      if (pix.hcount < xmin) xmin_nxt = pix.hcount;
      if (pix.hcount > xmax) xmax_nxt = pix.hcount;
      if (pix.vcount < ymin) ymin_nxt = pix.vcount;
      if (pix.vcount > ymax) ymax_nxt = pix.vcount;
    end
`endif
  end

  // Per-frame accumulation; every frame_end restarts the frame, accepted or not
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (!rst_n || pix.frame_end) begin
      cnt   <= '0;
      sum_x <= '0;
      sum_y <= '0;
`ifdef COLOR_CENTROID_BBOX_EN
      xmin  <= '1;
      xmax  <= '0;
      ymin  <= '1;
      ymax  <= '0;
`endif
    end else begin
      cnt   <= cnt_nxt;
      sum_x <= sx_nxt;
      sum_y <= sy_nxt;
`ifdef COLOR_CENTROID_BBOX_EN
      xmin  <= xmin_nxt;
      xmax  <= xmax_nxt;
      ymin  <= ymin_nxt;
      ymax  <= ymax_nxt;
`endif
    end
  end

  // Control FSM, divider datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      iter         <= '0;
      match        <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
      found        <= 1'b0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      match_count  <= '0;
      op_cnt       <= '0;
      op_sx        <= '0;
      op_sy        <= '0;
      rem_x        <= '0;
      rem_y        <= '0;
      q_x          <= '0;
      q_y          <= '0;
`ifdef COLOR_CENTROID_BBOX_EN
      op_xmin      <= '0;
      op_xmax      <= '0;
      op_ymin      <= '0;
      op_ymax      <= '0;
      bbox_xmin    <= '0;
      bbox_xmax    <= '0;
      bbox_ymin    <= '0;
      bbox_ymax    <= '0;
`endif
    end else begin
      match        <= hit;
      result_valid <= 1'b0;
      overrun      <= pix.frame_end && busy;
      case (state)
        DIVIDE: begin
          iter <= iter + IT_W'(1);
          if (iter == '0) begin
            // High dividend bits seed the remainder; valid because quotient < 2^X_W
            rem_x <= op_sx[SX_W-1:X_W];
            q_x   <= op_sx[X_W-1:0];
            rem_y <= sy_ext[SX_W-1:X_W];
            q_y   <= sy_ext[X_W-1:0];
          end else if (iter <= IT_W'(X_W)) begin
            rem_x <= rem_x_nxt;
            rem_y <= rem_y_nxt;
            q_x   <= {q_x[X_W-2:0], ge_x};
            q_y   <= {q_y[X_W-2:0], ge_y};
          end else begin
            match_count  <= op_cnt;
            found        <= (op_cnt != '0);
            if (op_cnt != '0) begin
              centroid_x <= q_x;
              centroid_y <= q_y[Y_W-1:0];
`ifdef COLOR_CENTROID_BBOX_EN
              bbox_xmin  <= op_xmin;
              bbox_xmax  <= op_xmax;
              bbox_ymin  <= op_ymin;
              bbox_ymax  <= op_ymax;
`endif
            end
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a frame_end and start a new division
          if (accept) begin
            op_cnt  <= cnt_nxt;
            op_sx   <= sx_nxt;
            op_sy   <= sy_nxt;
`ifdef COLOR_CENTROID_BBOX_EN
            op_xmin <= xmin_nxt;
            op_xmax <= xmax_nxt;
            op_ymin <= ymin_nxt;
            op_ymax <= ymax_nxt;
`endif
            iter    <= '0;
            busy    <= 1'b1;
            state   <= DIVIDE;
          end else begin
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_centroid.sv
// Directed bench for color_centroid: table-driven match checks plus
// hand-written frame sequences for the divider, overrun and reset cases.
`timescale 1ns/1ps
module tb_color_centroid;
  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int CNT_W = 20;
  localparam logic [23:0] TGT = 24'hE0_C0_C0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [23:0]      target_hsv;
  logic             match, result_valid, found, busy, overrun;
  logic [X_W-1:0]   centroid_x;
  logic [Y_W-1:0]   centroid_y;
  logic [CNT_W-1:0] match_count;
`ifdef COLOR_CENTROID_BBOX_EN
  logic [X_W-1:0]   bbox_xmin, bbox_xmax;
  logic [Y_W-1:0]   bbox_ymin, bbox_ymax;
`endif

  color_centroid_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  color_centroid #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix          (bus.slave),
    .target_hsv   (target_hsv),
    .match        (match),
    .centroid_x   (centroid_x),
    .centroid_y   (centroid_y),
    .match_count  (match_count),
    .result_valid (result_valid),
    .found        (found),
    .busy         (busy),
`ifdef COLOR_CENTROID_BBOX_EN
    .bbox_xmin    (bbox_xmin),
    .bbox_xmax    (bbox_xmax),
    .bbox_ymin    (bbox_ymin),
    .bbox_ymax    (bbox_ymax),
`endif
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [23:0] hsv;
    logic [23:0] tgt;
    int          x;
    int          y;
    logic        exp_match;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] hsv, input int x, input int y,
                       input logic fe);
    bus.pixel_valid = v;
    bus.tHSV        = hsv;
    bus.hcount      = X_W'(x);
    bus.vcount      = Y_W'(y);
    bus.frame_end   = fe;
    tick();
    bus.pixel_valid = 1'b0;
    bus.frame_end   = 1'b0;
  endtask

  task automatic hit(input int x, input int y);
    drive(1'b1, TGT, x, y, 1'b0);
  endtask

  // Clocks from now until result_valid is seen, bounded at 40
  task automatic wait_result(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!result_valid && n < 40);
  endtask

  task automatic check_result(input string tag, input int n, input int exp_n,
                              input int cx, input int cy, input int cnt, input logic fnd);
    check({tag, " latency"}, 32'(n), 32'(exp_n));
    check({tag, " centroid_x"}, 32'(centroid_x), 32'(cx));
    check({tag, " centroid_y"}, 32'(centroid_y), 32'(cy));
    check({tag, " match_count"}, 32'(match_count), 32'(cnt));
    check({tag, " found"}, 32'(found), 32'(fnd));
    check({tag, " busy at result"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic saw_match;

    vecs[0] = '{1'b1, 24'hE0C0C0, 24'hE0C0C0, 1, 2, 1'b1};
    vecs[1] = '{1'b0, 24'hE0C0C0, 24'hE0C0C0, 3, 3, 1'b0};
    vecs[2] = '{1'b1, 24'hE0C0C1, 24'hE0C0C0, 4, 4, 1'b0};
    vecs[3] = '{1'b1, 24'h123456, 24'h123456, 5, 6, 1'b1};
    vecs[4] = '{1'b1, 24'hE0C0C0, 24'h123456, 7, 7, 1'b0};
    vecs[5] = '{1'b1, 24'h000000, 24'h000000, 9, 10, 1'b1};

    bus.pixel_valid = 1'b0;
    bus.tHSV        = '0;
    bus.hcount      = '0;
    bus.vcount      = '0;
    bus.frame_end   = 1'b0;
    target_hsv      = TGT;

    repeat (3) tick();
    check("reset match", 32'(match), 32'd0);
    check("reset centroid", 32'({centroid_x, centroid_y}), 32'd0);
    check("reset count/found", 32'({match_count, found}), 32'd0);
    check("reset valid/busy/overrun", 32'({result_valid, busy, overrun}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table frame: match latency and target changes; hits (1,2) (5,6) (9,10)
    for (int i = 0; i < 6; i++) begin
      target_hsv = vecs[i].tgt;
      drive(vecs[i].valid, vecs[i].hsv, vecs[i].x, vecs[i].y, 1'b0);
      check($sformatf("table match %0d", i), 32'(match), 32'(vecs[i].exp_match));
    end
    target_hsv = TGT;
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    check("table busy after frame_end", 32'(busy), 32'd1);
    wait_result(n);
    check_result("table", n, 13, 5, 6, 3, 1'b1);
    tick();
    check("result_valid one cycle", 32'(result_valid), 32'd0);

    // Frame 1: three hits plus non-matching pixels
    hit(10, 20);
    drive(1'b1, 24'h00C0C0, 15, 15, 1'b0);
    hit(20, 40);
    hit(30, 60);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    wait_result(n);
    check_result("frame1", n, 13, 20, 40, 3, 1'b1);

    // Frame 2: nothing matches; centroid holds
    saw_match = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 24'h000000, i * 7, i, 1'b0);
      saw_match = saw_match | match;
    end
    check("frame2 match never set", 32'(saw_match), 32'd0);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    wait_result(n);
    check_result("frame2", n, 13, 20, 40, 0, 1'b0);

    // Frame 3a: truncation 7/2 = 3
    hit(3, 0);
    hit(4, 0);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    wait_result(n);
    check_result("frame3a", n, 13, 3, 0, 2, 1'b1);

    // Frame 3b: hit coinciding with frame_end is part of the closing frame
    hit(3, 0);
    hit(4, 0);
    drive(1'b1, TGT, 5, 0, 1'b1);
    wait_result(n);
    check_result("frame3b", n, 13, 4, 0, 3, 1'b1);

    // frame_end in the result cycle is accepted, not an overrun
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    check("done-cycle accept overrun", 32'(overrun), 32'd0);
    check("done-cycle accept busy", 32'(busy), 32'd1);
    wait_result(n);
    check_result("empty after done", n, 13, 4, 0, 0, 1'b0);

    // Overrun: second frame_end 5 clocks after the first
    hit(100, 50);
    hit(200, 150);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) hit(7, 7);
    drive(1'b1, TGT, 7, 7, 1'b1);
    check("overrun pulse", 32'(overrun), 32'd1);
    tick();
    check("overrun one cycle", 32'(overrun), 32'd0);
    wait_result(n);
    check_result("overrun first", n, 7, 150, 100, 2, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(result_valid);
    end
    check("no second result", 32'(pulses), 32'd0);
    hit(8, 9);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    wait_result(n);
    check_result("after overrun", n, 13, 8, 9, 1, 1'b1);

    // Reset mid-division
    hit(50, 50);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset centroid", 32'({centroid_x, centroid_y}), 32'd0);
    check("midreset count/found", 32'({match_count, found}), 32'd0);
    check("midreset valid/busy", 32'({result_valid, busy, overrun}), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(result_valid);
    end
    check("midreset no result", 32'(pulses), 32'd0);
    hit(6, 4);
    hit(8, 6);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    wait_result(n);
    check_result("post reset", n, 13, 7, 5, 2, 1'b1);

`ifdef COLOR_CENTROID_BBOX_EN
    hit(10, 20);
    hit(30, 5);
    drive(1'b0, 24'h0, 0, 0, 1'b1);
    wait_result(n);
    check_result("bbox frame", n, 13, 20, 12, 2, 1'b1);
    check("bbox_xmin", 32'(bbox_xmin), 32'd10);
    check("bbox_xmax", 32'(bbox_xmax), 32'd30);
    check("bbox_ymin", 32'(bbox_ymin), 32'd5);
    check("bbox_ymax", 32'(bbox_ymax), 32'd20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
